// File: rtl/emern_vt_pkg.sv
// emern_vt_pkg: shared timing constants for the raster timing generator.
//   - Default 640x480@60 porch/sync/active values and sync polarity.
//   - total(): sums the four segments of one axis into a line/frame total.
package emern_vt_pkg;

    localparam int unsigned VgaHActive = 640;
    localparam int unsigned VgaHFp     = 16;
    localparam int unsigned VgaHSync   = 96;
    localparam int unsigned VgaHBp     = 48;
    localparam int unsigned VgaVActive = 480;
    localparam int unsigned VgaVFp     = 10;
    localparam int unsigned VgaVSync   = 2;
    localparam int unsigned VgaVBp     = 33;
    localparam bit          VgaSyncPol = 1'b0;

    // Width of the delayed bundle {active, h_sync, v_sync}
    localparam int unsigned DlyWidth = 3;

    function automatic int unsigned total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/emern_video_timing_if.sv
// emern_video_timing_if: output bundle of the raster timing generator.
//   en           pixel-clock enable (driven by the consumer side)
//   col_out      current column
//   row_out      current row
//   active       visible-area flag (delayed)
//   h_sync       horizontal sync (delayed)
//   v_sync       vertical sync (delayed)
//   load_window  vertical-blank flag (undelayed)
//   line_start   end-of-line strobe
//   frame_start  end-of-frame strobe
//   frame_cnt    frame counter (only with EMERN_VT_FRAME_CNT_EN)
// master: the timing generator. slave: the pixel core / frontend.
interface emern_video_timing_if #(
    parameter int unsigned CW = 10
);
    logic          en;
    logic [CW-1:0] col_out;
    logic [CW-1:0] row_out;
    logic          active;
    logic          h_sync;
    logic          v_sync;
    logic          load_window;
    logic          line_start;
    logic          frame_start;
`ifdef EMERN_VT_FRAME_CNT_EN
    logic [7:0]    frame_cnt;
`endif

    modport master (
        input  en,
        output col_out,
        output row_out,
        output active,
        output h_sync,
        output v_sync,
        output load_window,
        output line_start,
`ifdef EMERN_VT_FRAME_CNT_EN
        output frame_cnt,
`endif
        output frame_start
    );

    modport slave (
        output en,
        input  col_out,
        input  row_out,
        input  active,
        input  h_sync,
        input  v_sync,
        input  load_window,
        input  line_start,
`ifdef EMERN_VT_FRAME_CNT_EN
        input  frame_cnt,
`endif
        input  frame_start
    );

endinterface

// File: rtl/emern_delay_line.sv
// emern_delay_line: enable-gated shift register of DEPTH stages, WIDTH bits each.
//   clk_i      clock
//   rst_ni     asynchronous active-low reset; every stage loads rst_val_i
//   en_i       shift enable; stages hold when low
//   rst_val_i  value all stages take under reset
//   d_i        input word
//   q_o        word shifted in DEPTH enabled cycles earlier (d_i itself when DEPTH=0)
module emern_delay_line #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] rst_val_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_bypass;
        assign unused_bypass = &{1'b0, clk_i, rst_ni, en_i, rst_val_i};
        assign q_o = d_i;
    end else begin : g_shift
        logic [DEPTH-1:0][WIDTH-1:0] stage_q;
        logic [DEPTH-1:0][WIDTH-1:0] stage_d;

        always_comb begin
            stage_d = stage_q;
            if (en_i) begin
                stage_d[0] = d_i;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                stage_q <= {DEPTH{rst_val_i}};
            end else begin
                stage_q <= stage_d;
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/emern_video_timing.sv
// emern_video_timing: parametrised raster timing generator.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   vt     emern_video_timing_if.master: en in; col/row counters, delayed active/h_sync/v_sync,
//          undelayed load_window, line_start/frame_start strobes, optional frame_cnt out.
// Optional feature macro: EMERN_VT_FRAME_CNT_EN adds the 8-bit frame counter.
module emern_video_timing
    import emern_vt_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = VgaHActive,
    parameter int unsigned H_FP       = VgaHFp,
    parameter int unsigned H_SYNC     = VgaHSync,
    parameter int unsigned H_BP       = VgaHBp,
    parameter int unsigned V_ACTIVE   = VgaVActive,
    parameter int unsigned V_FP       = VgaVFp,
    parameter int unsigned V_SYNC     = VgaVSync,
    parameter int unsigned V_BP       = VgaVBp,
    parameter bit          SYNC_POL   = VgaSyncPol,
    parameter int unsigned PIPE_DELAY = 1,
    parameter int unsigned CW         = 10
) (
    input logic                  clk,
    input logic                  rst_n,
    emern_video_timing_if.master vt
);

    localparam int unsigned H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HsStart = H_ACTIVE + H_FP;
    localparam int unsigned HsEnd   = HsStart + H_SYNC;
    localparam int unsigned VsStart = V_ACTIVE + V_FP;
    localparam int unsigned VsEnd   = VsStart + V_SYNC;

    localparam logic [CW-1:0] HLast = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] VLast = CW'(V_TOTAL - 1);

    if ((64'd1 << CW) < 64'(H_TOTAL) || (64'd1 << CW) < 64'(V_TOTAL)) begin : g_cw_check
        $error("emern_video_timing: CW too narrow for H_TOTAL/V_TOTAL");
    end
    if (PIPE_DELAY > 15) begin : g_delay_check
        $error("emern_video_timing: PIPE_DELAY must be 0..15");
    end

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic          col_wrap;
    logic          row_wrap;

    // >= rather than == so an out-of-range value can never persist
    assign col_wrap = (col_q >= HLast);
    assign row_wrap = (row_q >= VLast);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (vt.en) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = row_wrap ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Widened copies so decode limits equal to 2**CW compare correctly
    logic [31:0] col_w;
    logic [31:0] row_w;
    assign col_w = 32'(col_q);
    assign row_w = 32'(row_q);

    logic                hs_raw;
    logic                vs_raw;
    logic                act_raw;
    logic [DlyWidth-1:0] dly_in;
    logic [DlyWidth-1:0] dly_idle;
    logic [DlyWidth-1:0] dly_out;

    assign hs_raw  = (col_w >= HsStart) && (col_w < HsEnd);
    assign vs_raw  = (row_w >= VsStart) && (row_w < VsEnd);
    assign act_raw = (col_w < H_ACTIVE) && (row_w < V_ACTIVE);

    assign dly_in   = {act_raw, hs_raw ? SYNC_POL : ~SYNC_POL, vs_raw ? SYNC_POL : ~SYNC_POL};
    assign dly_idle = {1'b0, ~SYNC_POL, ~SYNC_POL};

    emern_delay_line #(
        .WIDTH(DlyWidth),
        .DEPTH(PIPE_DELAY)
    ) u_delay (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .en_i     (vt.en),
        .rst_val_i(dly_idle),
        .d_i      (dly_in),
        .q_o      (dly_out)
    );

    logic line_start;
    logic frame_start;
    assign line_start  = vt.en && (col_q == HLast);
    assign frame_start = line_start && (row_q == VLast);

    assign vt.col_out     = col_q;
    assign vt.row_out     = row_q;
    assign vt.active      = dly_out[2];
    assign vt.h_sync      = dly_out[1];
    assign vt.v_sync      = dly_out[0];
    assign vt.load_window = (row_w >= V_ACTIVE);
    assign vt.line_start  = line_start;
    assign vt.frame_start = frame_start;

`ifdef EMERN_VT_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 8'd0;
        end else if (frame_start) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign vt.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_emern_video_timing.sv
// tb_emern_video_timing: scoreboard bench for emern_video_timing.
// Two DUTs share clock, reset and enable: one with no pipeline delay, one with PIPE_DELAY=3.
// The reference model tracks only the number of enabled edges since reset and derives every
// output from that count with plain division/modulo.
module tb_emern_video_timing;

    localparam int unsigned HA = 10, HFP = 2, HS = 3, HBP = 2;
    localparam int unsigned VA = 6, VFP = 1, VS = 2, VBP = 1;
    localparam int unsigned HT = HA + HFP + HS + HBP;
    localparam int unsigned VT = VA + VFP + VS + VBP;
    localparam longint      FRAME = longint'(HT) * longint'(VT);
    localparam bit          SP = 1'b0;
    localparam int unsigned CW = 5;
    localparam int          D1 = 3;

    typedef struct {
        int col;
        int row;
        bit act0, hs0, vs0;
        bit act1, hs1, vs1;
        bit lw, ls, fs;
        int fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   en_cur = 1'b1;
    longint t = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    emern_video_timing_if #(.CW(CW)) vif0 ();
    emern_video_timing_if #(.CW(CW)) vif1 ();

    emern_video_timing #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(SP), .PIPE_DELAY(0), .CW(CW)
    ) dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .vt   (vif0)
    );

    emern_video_timing #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(SP), .PIPE_DELAY(D1), .CW(CW)
    ) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .vt   (vif1)
    );

    // {active, h_sync, v_sync} for the raster position reached after u enabled edges;
    // negative u means the delay line still holds its reset fill.
    function automatic logic [2:0] dec(input longint u);
        longint c, r;
        if (u < 0) return {1'b0, ~SP, ~SP};
        c = u % HT;
        r = (u / HT) % VT;
        return {(c < HA) && (r < VA),
                (c >= HA + HFP && c < HA + HFP + HS) ? SP : ~SP,
                (r >= VA + VFP && r < VA + VFP + VS) ? SP : ~SP};
    endfunction

    function automatic exp_t model(input longint tt, input bit en_now);
        exp_t e;
        logic [2:0] d0, d1;
        e.col = int'(tt % HT);
        e.row = int'((tt / HT) % VT);
        // With no delay, active is a plain decode of (0,0) even under reset.
        d0 = dec(tt);
        d1 = dec(tt - D1);
        {e.act0, e.hs0, e.vs0} = d0;
        {e.act1, e.hs1, e.vs1} = d1;
        e.lw = (e.row >= VA);
        e.ls = en_now && (e.col == HT - 1);
        e.fs = e.ls && (e.row == VT - 1);
        e.fc = int'((tt / FRAME) % 256);
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0d actual=%0d required=%0d", name, t, act, req);
        end
    endtask

    // One cycle: account for the edge just taken, then drive new inputs and predict outputs.
    task automatic step(input bit en_v, input bit rst_v);
        @(posedge clk);
        if (rst_n && en_cur) t++;
        #1;
        rst_n = rst_v;
        if (!rst_v) t = 0;
        en_cur  = en_v;
        vif0.en = en_v;
        vif1.en = en_v;
        sb.push_back(model(t, en_v));
    endtask

    // Monitor: outputs are presented every cycle; compare at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("col0", int'(vif0.col_out), e.col);
                chk("row0", int'(vif0.row_out), e.row);
                chk("col1", int'(vif1.col_out), e.col);
                chk("row1", int'(vif1.row_out), e.row);
                chk("active0", int'(vif0.active), int'(e.act0));
                chk("hsync0", int'(vif0.h_sync), int'(e.hs0));
                chk("vsync0", int'(vif0.v_sync), int'(e.vs0));
                chk("active3", int'(vif1.active), int'(e.act1));
                chk("hsync3", int'(vif1.h_sync), int'(e.hs1));
                chk("vsync3", int'(vif1.v_sync), int'(e.vs1));
                chk("load_window", int'(vif0.load_window), int'(e.lw));
                chk("line_start", int'(vif0.line_start), int'(e.ls));
                chk("frame_start", int'(vif0.frame_start), int'(e.fs));
                chk("load_window3", int'(vif1.load_window), int'(e.lw));
                chk("line_start3", int'(vif1.line_start), int'(e.ls));
                chk("frame_start3", int'(vif1.frame_start), int'(e.fs));
`ifdef EMERN_VT_FRAME_CNT_EN
                chk("frame_cnt0", int'(vif0.frame_cnt), e.fc);
                chk("frame_cnt3", int'(vif1.frame_cnt), e.fc);
`endif
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        vif0.en = 1'b1;
        vif1.en = 1'b1;
        // Reset held with en=1
        repeat (3) step(1'b1, 1'b0);
        // Free run: two full frames plus a little
        repeat (2 * FRAME + 20) step(1'b1, 1'b1);
        // Alternating enable
        for (int i = 0; i < 400; i++) step(i[0] == 1'b0, 1'b1);
        // Random enable
        repeat (1200) step($urandom_range(0, 3) != 0, 1'b1);
        // Run to a mid-frame position, then pulse reset
        guard = 0;
        while (!(((t / HT) % VT) == 3 && (t % HT) == 8) && guard < 2 * FRAME) begin
            step(1'b1, 1'b1);
            guard++;
        end
        chk("reach_midframe", int'(guard < 2 * FRAME), 1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        repeat (FRAME + 30) step($urandom_range(0, 4) != 0, 1'b1);
`ifdef EMERN_VT_FRAME_CNT_EN
        // Enough frames for the counter to pass 255 and wrap
        repeat (257 * FRAME + 20) step(1'b1, 1'b1);
`endif
        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
